// File: rtl/mem_defs.sv
// Shared store/load op codes, drain FSM encoding and small decode helpers
// for the data-memory store path.
package mem_defs;

  localparam logic [2:0] ST_SW = 3'd1;
  localparam logic [2:0] ST_SB = 3'd2;
  localparam logic [2:0] ST_SH = 3'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

  function automatic logic is_store_op(input logic [2:0] op);
    return (op == ST_SW) || (op == ST_SB) || (op == ST_SH);
  endfunction

  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lsb);
    case (op)
      ST_SW:   return lsb == 2'b00;
      ST_SH:   return !lsb[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Committed-store buffer: DEPTH entries of {word address, byte enable, lane data},
// first-word-fall-through read at the head.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 66
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, so resetting the pointers and count is enough.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_store_ctrl.sv
// Store-side lane aligner, store buffer and data-memory drain handshake.
// Optional build macro ADES_EXC_EN: raise AdES on misaligned stores instead of force-aligning.
module mem_store_ctrl
  import mem_defs::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [2:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_wdata,
  input  logic          st_flush,
  output logic          st_ready,
  output logic          exc_ades,
  output logic [AW-1:0] exc_badva,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  output logic          buf_empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + 34;

  drain_state_t  state;
  logic [1:0]    lsb;
  logic [3:0]    enc_be;
  logic [31:0]   enc_data;
  logic          accept_try;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  // NOTE: every combinational output gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lsb      = st_addr[1:0];
    enc_be   = 4'b0000;
    enc_data = st_wdata;
    case (st_op)
      ST_SW: begin
        lsb    = 2'b00;
        enc_be = 4'b1111;
      end
      ST_SH: begin
        lsb      = {st_addr[1], 1'b0};
        enc_be   = lsb[1] ? 4'b1100 : 4'b0011;
        enc_data = {2{st_wdata[15:0]}};
      end
      ST_SB: begin
        enc_be   = 4'b0001 << lsb;
        enc_data = {4{st_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // A full buffer still accepts when the head leaves in the same cycle.
  assign pop        = (state == REQ) && bus_ack;
  assign st_ready   = !full || pop;
  assign accept_try = st_valid && is_store_op(st_op) && !st_flush && st_ready;

`ifdef ADES_EXC_EN
  logic misaligned;
  assign misaligned = !is_aligned(st_op, st_addr[1:0]);
  assign push       = accept_try && !misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_ades  <= 1'b0;
      exc_badva <= '0;
    end else begin
      exc_ades  <= accept_try && misaligned;
      exc_badva <= (accept_try && misaligned) ? st_addr : '0;
    end
  end
`else
  assign push      = accept_try;
  assign exc_ades  = 1'b0;
  assign exc_badva = '0;
`endif

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   ({st_addr[AW-1:2], enc_be, enc_data}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Entering REQ on the push edge itself gives the one-cycle first-store latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (push) state <= REQ;
        REQ:     if (bus_ack && count == CW'(1) && !push) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_req   = (state == REQ);
  assign bus_addr  = bus_req ? {head[EW-1:36], 2'b00} : '0;
  assign bus_be    = bus_req ? head[35:32] : 4'b0000;
  assign bus_wdata = bus_req ? head[31:0] : 32'h0;
  assign buf_empty = empty && (state == IDLE);

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Self-checking bench for mem_store_ctrl: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_store_ctrl;
  import mem_defs::*;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic [2:0]    st_op;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic          st_flush;
  logic          st_ready;
  logic          exc_ades;
  logic [AW-1:0] exc_badva;
  logic          bus_req;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic          buf_empty;

  always #5 clk = ~clk;

  mem_store_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .st_valid  (st_valid),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_wdata  (st_wdata),
    .st_flush  (st_flush),
    .st_ready  (st_ready),
    .exc_ades  (exc_ades),
    .exc_badva (exc_badva),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .buf_empty (buf_empty)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic        m_exc;
  logic [31:0] m_badva;
  logic        m_pop, m_ready, m_try, m_bad;

  function automatic entry_t encode(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    entry_t e;
    e.addr = a & ~32'h3;
    e.be   = 4'hF;
    e.data = d;
    if (op == 3'd3) begin
      e.be   = a[1] ? 4'hC : 4'h3;
      e.data = {16'h0, d[15:0]} * 32'h0001_0001;
    end else if (op == 3'd2) begin
      e.be   = 4'(1 << (a % 4));
      e.data = {24'h0, d[7:0]} * 32'h0101_0101;
    end
    return e;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd1) return (a % 4) != 0;
    if (op == 3'd3) return (a % 2) != 0;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_exc   = 1'b0;
      m_badva = 32'h0;
    end else begin
      m_pop   = (q.size() != 0) && bus_ack;
      m_ready = (q.size() < DEPTH) || m_pop;
      m_try   = st_valid && (st_op inside {3'd1, 3'd2, 3'd3}) && !st_flush && m_ready;
      m_bad   = is_misaligned(st_op, st_addr);
`ifdef ADES_EXC_EN
      m_exc   = m_try && m_bad;
      m_badva = m_exc ? st_addr : 32'h0;
      m_try   = m_try && !m_bad;
`else
      m_exc   = 1'b0;
      m_badva = 32'h0;
`endif
      if (m_pop) void'(q.pop_front());
      if (m_try) q.push_back(encode(st_op, st_addr, st_wdata));
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m.bus_req", bus_req, q.size() != 0);
      if (q.size() != 0) begin
        check("m.bus_addr", bus_addr, q[0].addr);
        check("m.bus_be", bus_be, q[0].be);
        check("m.bus_wdata", bus_wdata, q[0].data);
      end else begin
        check("m.bus_addr_idle", bus_addr, 32'h0);
        check("m.bus_be_idle", bus_be, 32'h0);
        check("m.bus_wdata_idle", bus_wdata, 32'h0);
      end
      check("m.st_ready", st_ready, (q.size() < DEPTH) || ((q.size() != 0) && bus_ack));
      check("m.buf_empty", buf_empty, q.size() == 0);
      check("m.exc_ades", exc_ades, m_exc);
      check("m.exc_badva", exc_badva, m_badva);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic fl, input logic ack);
    @(posedge clk);
    #1;
    st_valid = v;
    st_op    = op;
    st_addr  = a;
    st_wdata = d;
    st_flush = fl;
    bus_ack  = ack;
  endtask

  task automatic idle(input int n, input logic ack);
    repeat (n) drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, ack);
  endtask

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_op    = 3'd0;
    st_addr  = '0;
    st_wdata = '0;
    st_flush = 1'b0;
    bus_ack  = 1'b0;
    cmp_en   = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.bus_req", bus_req, 1'b0);
    check("rst.st_ready", st_ready, 1'b1);
    check("rst.buf_empty", buf_empty, 1'b1);
    check("rst.exc_ades", exc_ades, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b1);

    // sb into lane 3, first-store latency of one cycle
    drive(1'b1, ST_SB, 32'h13, 32'h0000_00A5, 1'b0, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t1.bus_req", bus_req, 1'b1);
    check("t1.bus_addr", bus_addr, 32'h10);
    check("t1.bus_be", bus_be, 4'b1000);
    check("t1.bus_wdata", bus_wdata, 32'hA5A5_A5A5);
    idle(3, 1'b1);

    // sh into upper half
    drive(1'b1, ST_SH, 32'h22, 32'h1234_BEEF, 1'b0, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t2.bus_be", bus_be, 4'b1100);
    check("t2.bus_wdata", bus_wdata, 32'hBEEF_BEEF);
    check("t2.bus_addr", bus_addr, 32'h20);
    idle(3, 1'b1);

    // fill with ack low, stall the third, then pop+push in one cycle
    drive(1'b1, ST_SW, 32'h100, 32'h1111_1111, 1'b0, 1'b0);
    drive(1'b1, ST_SW, 32'h104, 32'h2222_2222, 1'b0, 1'b0);
    drive(1'b1, ST_SW, 32'h108, 32'h3333_3333, 1'b0, 1'b0);
    @(negedge clk);
    check("t3.stall_ready", st_ready, 1'b0);
    check("t3.head0", bus_wdata, 32'h1111_1111);
    drive(1'b1, ST_SW, 32'h108, 32'h3333_3333, 1'b0, 1'b1);
    @(negedge clk);
    check("t3.ready_on_ack", st_ready, 1'b1);
    idle(1, 1'b0);
    @(negedge clk);
    check("t3.head1", bus_wdata, 32'h2222_2222);
    check("t3.head1_addr", bus_addr, 32'h104);
    check("t3.still_full", st_ready, 1'b0);
    idle(1, 1'b0);
    idle(4, 1'b1);
    @(negedge clk);
    check("t3.drained", buf_empty, 1'b1);

    // misaligned sw
    drive(1'b1, ST_SW, 32'h06, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
`ifdef ADES_EXC_EN
    check("t4.exc_ades", exc_ades, 1'b1);
    check("t4.exc_badva", exc_badva, 32'h06);
    check("t4.no_req", bus_req, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    check("t4.exc_one_cycle", exc_ades, 1'b0);
`else
    check("t4.bus_addr", bus_addr, 32'h04);
    check("t4.bus_be", bus_be, 4'b1111);
    check("t4.exc_ades", exc_ades, 1'b0);
    idle(1, 1'b0);
`endif
    idle(3, 1'b1);

    // flushed store is dropped
    drive(1'b1, ST_SW, 32'h40, 32'hDEAD_0000, 1'b1, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t5.buf_empty", buf_empty, 1'b1);
    check("t5.exc_ades", exc_ades, 1'b0);
    check("t5.no_req", bus_req, 1'b0);

    // model-only stream: bad op code, lane walk, misaligned sh, back-to-back
    drive(1'b1, 3'd5, 32'h80, 32'h5555_5555, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      drive(1'b1, ST_SB, 32'h200 + i, 32'h10 + i, 1'b0, 1'b1);
    drive(1'b1, ST_SH, 32'h21, 32'h0000_ABCD, 1'b0, 1'b1);
    drive(1'b1, ST_SW, 32'h300, 32'h0BAD_F00D, 1'b0, 1'b1);
    drive(1'b1, ST_SH, 32'h306, 32'h7777_4321, 1'b0, 1'b1);
    idle(4, 1'b1);

    // async reset with two pending
    drive(1'b1, ST_SW, 32'h400, 32'hAAAA_0001, 1'b0, 1'b0);
    drive(1'b1, ST_SW, 32'h404, 32'hAAAA_0002, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    check("t6.req_before", bus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6.req_drop", bus_req, 1'b0);
    check("t6.empty_in_rst", buf_empty, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b1);
    @(negedge clk);
    check("t6.empty_after", buf_empty, 1'b1);
    check("t6.req_after", bus_req, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
